// File: rtl/track_mode_arbiter_if.sv
// Bundle between the tracker channels, keyboard/VGA timing and the arbiter outputs.
interface track_mode_arbiter_if #(
   parameter int NUM_SRC = 4,
   parameter int X_W     = 10,
   parameter int Y_W     = 10,
   parameter int COLOR_W = 4
);
   localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic                         v_sync;
   logic [7:0]                   key_data;
   logic                         key_valid;
   logic [NUM_SRC*X_W-1:0]       src_x;
   logic [NUM_SRC*Y_W-1:0]       src_y;
   logic [NUM_SRC-1:0]           src_detect;
   logic [NUM_SRC-1:0]           src_shoot;
   logic [NUM_SRC-1:0]           src_target_off;
   logic [NUM_SRC*3*COLOR_W-1:0] src_rgb;

   logic [COLOR_W-1:0]           r_port;
   logic [COLOR_W-1:0]           g_port;
   logic [COLOR_W-1:0]           b_port;
   logic [SEL_W-1:0]             active_sel;
   logic                         fallback_en;
   logic [X_W-1:0]               x_coor;
   logic [Y_W-1:0]               y_coor;
   logic                         red_detect;
   logic                         shoot;
   logic                         target_off;
   logic                         coasting;
   logic                         frame_valid;

   modport master (
      output v_sync, key_data, key_valid, src_x, src_y, src_detect,
             src_shoot, src_target_off, src_rgb,
      input  r_port, g_port, b_port, active_sel, fallback_en, x_coor, y_coor,
             red_detect, shoot, target_off, coasting, frame_valid
   );

   modport slave (
      input  v_sync, key_data, key_valid, src_x, src_y, src_detect,
             src_shoot, src_target_off, src_rgb,
      output r_port, g_port, b_port, active_sel, fallback_en, x_coor, y_coor,
             red_detect, shoot, target_off, coasting, frame_valid
   );
endinterface

// File: rtl/track_mode_arbiter.sv
// N-source tracking selector: channel switches only at frame boundaries,
// coordinates coast for a bounded number of missed frames, optional
// fallback to any channel that sees a target.
module track_mode_arbiter #(
   parameter int         NUM_SRC     = 4,
   parameter int         X_W         = 10,
   parameter int         Y_W         = 10,
   parameter int         COLOR_W     = 4,
   parameter int         HOLD_FRAMES = 8,
   parameter logic [7:0] KEY_BASE    = 8'h31,
   parameter logic [7:0] KEY_FB      = 8'h46,
   parameter bit         VSYNC_POL   = 1'b0
) (
   input logic                 clk,
   input logic                 reset,
   track_mode_arbiter_if.slave bus
);
   localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int MISS_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
   localparam int PIX_W  = 3 * COLOR_W;
   localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(HOLD_FRAMES);

   logic              vs_q;
   logic              vs_act;
   logic              fb;
   logic [8:0]        key_off;
   logic              key_sel_hit;
   logic              key_fb_hit;
   logic [SEL_W-1:0]  pend_sel;
   logic [SEL_W-1:0]  next_sel;
   logic [SEL_W-1:0]  fb_idx;
   logic              fb_found;
   logic              cur_det;
   logic              lost;
   logic              take_fb;
   logic [MISS_W-1:0] miss_cnt;

   // Frame boundary = first cycle v_sync is at its active level.
   always_comb begin
      vs_act = VSYNC_POL ? bus.v_sync : ~bus.v_sync;
      fb     = vs_act & ~vs_q;
   end

   // Key decode; the 9-bit difference catches codes below KEY_BASE via bit 8.
   always_comb begin
      key_off     = {1'b0, bus.key_data} - {1'b0, KEY_BASE};
      key_sel_hit = bus.key_valid && !key_off[8] && (key_off < 9'(NUM_SRC));
      key_fb_hit  = bus.key_valid && (bus.key_data == KEY_FB);
   end

   // Lowest detecting channel other than the one that just finished its frame.
   always_comb begin
      fb_found = 1'b0;
      fb_idx   = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         if (!fb_found && (SEL_W'(j) != bus.active_sel) && bus.src_detect[j]) begin
            fb_found = 1'b1;
            fb_idx   = SEL_W'(j);
         end
      end
   end

   // Channel choice for the next frame; a key press in this cycle suppresses fallback.
   always_comb begin
      cur_det  = bus.src_detect[bus.active_sel];
      lost     = !cur_det && (miss_cnt == MISS_MAX);
      take_fb  = bus.fallback_en && lost && !bus.key_valid && fb_found;
      next_sel = take_fb ? fb_idx : pend_sel;
   end

   // v_sync edge register, reset to the inactive level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) vs_q <= 1'b0;
      else        vs_q <= vs_act;
   end

   // Pending selection: keys update it; a fallback switch pins it to the new channel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                pend_sel <= '0;
      else if (key_sel_hit)      pend_sel <= key_off[SEL_W-1:0];
      else if (fb && take_fb)    pend_sel <= fb_idx;
   end

   // Fallback enable toggles on its key.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          bus.fallback_en <= 1'b0;
      else if (key_fb_hit) bus.fallback_en <= ~bus.fallback_en;
   end

   // Pixel path follows active_sel, which only moves on frame boundaries.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.r_port <= '0;
         bus.g_port <= '0;
         bus.b_port <= '0;
      end else begin
         {bus.r_port, bus.g_port, bus.b_port} <= bus.src_rgb[bus.active_sel*PIX_W +: PIX_W];
      end
   end

   // Per-frame packet latch from the finishing channel, then channel switch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.active_sel  <= '0;
         bus.x_coor      <= '0;
         bus.y_coor      <= '0;
         bus.red_detect  <= 1'b0;
         bus.shoot       <= 1'b0;
         bus.target_off  <= 1'b0;
         bus.coasting    <= 1'b0;
         bus.frame_valid <= 1'b0;
         miss_cnt        <= MISS_MAX;
      end else begin
         bus.frame_valid <= fb;
         if (fb) begin
            bus.active_sel <= next_sel;
            if (cur_det) begin
               bus.x_coor     <= bus.src_x[bus.active_sel*X_W +: X_W];
               bus.y_coor     <= bus.src_y[bus.active_sel*Y_W +: Y_W];
               bus.shoot      <= bus.src_shoot[bus.active_sel];
               bus.target_off <= bus.src_target_off[bus.active_sel];
               bus.red_detect <= 1'b1;
               bus.coasting   <= 1'b0;
               miss_cnt       <= '0;
            end else if (miss_cnt != MISS_MAX) begin
               bus.shoot      <= 1'b0;
               bus.target_off <= bus.src_target_off[bus.active_sel];
               bus.red_detect <= 1'b1;
               bus.coasting   <= 1'b1;
               miss_cnt       <= miss_cnt + MISS_W'(1);
            end else begin
               bus.shoot      <= 1'b0;
               bus.red_detect <= 1'b0;
               bus.coasting   <= 1'b0;
            end
            // A new channel starts from the lost state; coordinates stay put.
            if (next_sel != bus.active_sel) miss_cnt <= MISS_MAX;
         end
      end
   end
endmodule

// File: tb/tb_track_mode_arbiter.sv
// Directed bench for track_mode_arbiter with hand-computed expectations.
module tb_track_mode_arbiter;
   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   track_mode_arbiter_if #(.NUM_SRC(4), .X_W(10), .Y_W(10), .COLOR_W(4)) bus ();

   track_mode_arbiter #(
      .NUM_SRC(4), .X_W(10), .Y_W(10), .COLOR_W(4), .HOLD_FRAMES(8),
      .KEY_BASE(8'h31), .KEY_FB(8'h46), .VSYNC_POL(1'b0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count a comparison and report it when it differs.
   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // v_sync goes active; the next edge is the frame boundary; sample just after it.
   task automatic frame_edge();
      bus.v_sync = 1'b0;
      tick();
   endtask

   task automatic frame_rest(input int n);
      bus.v_sync = 1'b1;
      repeat (n) tick();
   endtask

   task automatic press(input logic [7:0] code);
      bus.key_data  = code;
      bus.key_valid = 1'b1;
      tick();
      bus.key_valid = 1'b0;
   endtask

   function automatic int pix();
      return int'({bus.r_port, bus.g_port, bus.b_port});
   endfunction

   initial begin
      reset              = 1'b0;
      bus.v_sync         = 1'b1;
      bus.key_data       = 8'h00;
      bus.key_valid      = 1'b0;
      bus.src_x          = {10'd555, 10'd333, 10'd111, 10'd320};
      bus.src_y          = {10'd66,  10'd444, 10'd222, 10'd240};
      bus.src_detect     = 4'b0001;
      bus.src_shoot      = 4'b0001;
      bus.src_target_off = 4'b0000;
      bus.src_rgb        = {12'habc, 12'h789, 12'h456, 12'h123};

      // Reset state
      #12;
      check_val("rst_x", int'(bus.x_coor), 0);
      check_val("rst_red", int'(bus.red_detect), 0);
      check_val("rst_sel", int'(bus.active_sel), 0);
      check_val("rst_fv", int'(bus.frame_valid), 0);
      check_val("rst_fben", int'(bus.fallback_en), 0);
      check_val("rst_pix", pix(), 0);
      reset = 1'b1;
      tick();
      tick();
      check_val("pix_ch0", pix(), 12'h123);
      check_val("x_before_fb", int'(bus.x_coor), 0);

      // First frame boundary latches channel 0
      frame_edge();
      check_val("f1_x", int'(bus.x_coor), 320);
      check_val("f1_y", int'(bus.y_coor), 240);
      check_val("f1_red", int'(bus.red_detect), 1);
      check_val("f1_fv", int'(bus.frame_valid), 1);
      check_val("f1_sel", int'(bus.active_sel), 0);
      check_val("f1_shoot", int'(bus.shoot), 1);
      frame_rest(1);
      check_val("f1_fv_pulse", int'(bus.frame_valid), 0);

      // Key selects channel 2 mid-frame; pixels switch only after the boundary
      press(8'h33);
      tick();
      check_val("mid_sel", int'(bus.active_sel), 0);
      check_val("mid_pix", pix(), 12'h123);
      frame_edge();
      check_val("sw_sel", int'(bus.active_sel), 2);
      check_val("sw_pix_old", pix(), 12'h123);
      tick();
      check_val("sw_pix_new", pix(), 12'h789);
      frame_rest(2);

      // Back to channel 0; channel 2 has no target so its packet is lost
      press(8'h31);
      frame_edge();
      check_val("back_sel", int'(bus.active_sel), 0);
      check_val("back_red", int'(bus.red_detect), 0);
      check_val("back_x_held", int'(bus.x_coor), 320);
      frame_rest(2);
      frame_edge();
      check_val("reacq_red", int'(bus.red_detect), 1);
      frame_rest(2);

      // Coasting for 8 frames, lost on the 9th
      bus.src_detect     = 4'b0000;
      bus.src_x[9:0]     = 10'd500;
      bus.src_target_off = 4'b0001;
      for (int f = 1; f <= 10; f++) begin
         frame_edge();
         check_val($sformatf("coast%0d_red", f), int'(bus.red_detect), (f <= 8) ? 1 : 0);
         check_val($sformatf("coast%0d_coast", f), int'(bus.coasting), (f <= 8) ? 1 : 0);
         check_val($sformatf("coast%0d_x", f), int'(bus.x_coor), 320);
         check_val($sformatf("coast%0d_shoot", f), int'(bus.shoot), 0);
         if (f == 1) check_val("coast_toff", int'(bus.target_off), 1);
         frame_rest(2);
      end

      // Fallback on: lost channel 0 hands over to channel 1
      press(8'h46);
      tick();
      check_val("fben_on", int'(bus.fallback_en), 1);
      bus.src_detect = 4'b1010;
      frame_edge();
      check_val("fb_sel", int'(bus.active_sel), 1);
      check_val("fb_red", int'(bus.red_detect), 0);
      frame_rest(2);
      frame_edge();
      check_val("fb_x", int'(bus.x_coor), 111);
      check_val("fb_sel_stay", int'(bus.active_sel), 1);
      frame_rest(2);

      // Fallback off: lost channel 0 stays selected
      press(8'h46);
      tick();
      check_val("fben_off", int'(bus.fallback_en), 0);
      press(8'h31);
      frame_edge();
      check_val("nofb_to0", int'(bus.active_sel), 0);
      frame_rest(2);
      frame_edge();
      check_val("nofb_sel", int'(bus.active_sel), 0);
      check_val("nofb_red", int'(bus.red_detect), 0);
      frame_rest(2);

      // Key in the boundary cycle takes effect one frame later
      bus.key_data  = 8'h32;
      bus.key_valid = 1'b1;
      bus.v_sync    = 1'b0;
      tick();
      bus.key_valid = 1'b0;
      check_val("keyfb_sel_old", int'(bus.active_sel), 0);
      frame_rest(2);
      frame_edge();
      check_val("keyfb_sel_new", int'(bus.active_sel), 1);
      frame_rest(2);

      // Invalid key ignored
      press(8'h39);
      frame_edge();
      check_val("badkey_sel", int'(bus.active_sel), 1);
      check_val("badkey_fben", int'(bus.fallback_en), 0);
      check_val("badkey_x", int'(bus.x_coor), 111);
      frame_rest(2);

      // Reset while coasting
      bus.src_detect = 4'b0000;
      frame_edge();
      check_val("pre_rst_coast", int'(bus.coasting), 1);
      frame_rest(3);
      reset = 1'b0;
      #2;
      check_val("mrst_x", int'(bus.x_coor), 0);
      check_val("mrst_red", int'(bus.red_detect), 0);
      check_val("mrst_coast", int'(bus.coasting), 0);
      check_val("mrst_sel", int'(bus.active_sel), 0);
      check_val("mrst_pix", pix(), 0);
      tick();
      reset = 1'b1;
      tick();
      tick();
      check_val("post_rst_x", int'(bus.x_coor), 0);
      bus.src_detect = 4'b0001;
      frame_edge();
      check_val("post_rst_fb_x", int'(bus.x_coor), 500);
      check_val("post_rst_fb_sel", int'(bus.active_sel), 0);
      check_val("post_rst_fb_red", int'(bus.red_detect), 1);
      frame_rest(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
